ring_monitor: RTL and testbench
===============================

// Module: ring_monitor
// PURPOSE
//  Downstream checker/supervisor for the 4-bit one-hot ring counter. Samples the
//  ring state every enabled cycle, verifies one-hot and correct rotation, counts
//  full revolutions and errors, and, after a run of bad samples, drives the
//  ring's clear/preset lines for one cycle to reload it to 1000.
// PARAMETERS
//  WIDTH      4   ring width in bits (one-hot)
//  REV_W      16  width of revolution counter
//  ERR_LIMIT  3   consecutive bad enabled samples that trigger a resync (>=1)
// PORTS
//  in_clk        in   1        clock, rising edge
//  in_rst_n      in   1        synchronous active-low reset
//  in_en         in   1        monitor enable; low = freeze state, no checks
//  in_q          in   WIDTH    ring counter state being monitored
//  in_err_ack    in   1        clears o_err_sticky
//  o_clr         out  1        to ring clr; high one cycle in RESYNC
//  o_prst        out  1        to ring prst; high one cycle in RESYNC
//  o_locked      out  1        high while state == LOCK
//  o_err         out  1        one-cycle pulse per detected error
//  o_err_sticky  out  1        set on any error, held until ack/reset
//  o_rev_cnt     out  REV_W    completed revolutions, wraps modulo 2^REV_W
//  o_err_cnt     out  8        error count, saturates at 255
// BEHAVIOUR
//  - All outputs registered or decoded from state register; no comb in->out path.
//  - Reset (in_rst_n=0 at edge): state SEEK, prev=0, bad=0, all outputs 0,
//    counters 0, sticky 0. Reset wins over every other event, any state.
//  - Legal sequence: 1000 -> 0100 -> 0010 -> 0001 -> 1000 (MSB toward LSB, wrap).
//    exp = {prev[0], prev[WIDTH-1:1]}. one-hot = exactly one bit set.
//  - FSM: SEEK, LOCK, FAULT, RESYNC, SETTLE. In SEEK/LOCK/FAULT nothing changes
//    while in_en=0. RESYNC and SETTLE always advance regardless of in_en.
//  - SEEK: in_q one-hot -> prev<=in_q, bad<=0, LOCK. Else bad++; bad reaching
//    ERR_LIMIT -> RESYNC. No o_err in SEEK.
//  - LOCK: in_q==exp -> prev<=in_q; if prev==0001 and in_q==1000, o_rev_cnt++.
//    in_q!=exp -> o_err pulse next cycle, o_err_cnt++ (sat), sticky<=1,
//    bad<=1, FAULT (or RESYNC directly if ERR_LIMIT==1).
//  - FAULT: in_q one-hot -> prev<=in_q, bad<=0, LOCK (relock, no rev count).
//    Else bad++; bad reaching ERR_LIMIT -> RESYNC. No further o_err in FAULT.
//  - RESYNC: o_clr=o_prst=1 for exactly this one cycle (ring loads 1000), -> SETTLE.
//  - SETTLE: one cycle, in_q ignored, bad<=0, -> SEEK.
//  - o_locked=1 iff state==LOCK; deasserts the cycle after the bad sample.
//  - in_err_ack and a new error same cycle: sticky stays 1 (error wins).
//  - o_err_cnt at 255 holds; o_rev_cnt at 2^REV_W-1 wraps to 0.
//  - Latency: sample at edge N reflected on outputs after edge N (1 cycle).
// TESTING
//  1 Reset then ring preset to 1000, free-running 8 cycles, in_en=1 -> o_locked=1
//    from cycle 2, o_rev_cnt=1 after 0001->1000, o_err never pulses.
//  2 In LOCK force in_q=0110 one cycle then correct sequence -> single o_err
//    pulse, o_err_cnt=1, sticky=1, relock on next one-hot, no o_clr.
//  3 Force in_q=0000 for 3 enabled cycles -> FAULT then RESYNC; o_clr=o_prst=1
//    exactly one cycle; SETTLE; SEEK relocks on 0100 with o_locked=1.
//  4 in_en=0 for 5 cycles with garbage in_q -> no state/counter/output change;
//    re-enable on valid exp -> stays locked.
//  5 Error and in_err_ack same cycle -> sticky=1; ack alone later -> sticky=0.
//    Force 256 errors -> o_err_cnt=255 held.
//  6 Assert in_rst_n=0 during RESYNC -> next cycle o_clr=0, all outputs 0, SEEK.

Source files
------------

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - one-hot ring counter supervisor with rotation check and resync
// Verifies rotation, counts revolutions/errors, reloads the ring after repeated bad samples.
module ring_monitor #(
  parameter int WIDTH     = 4,
  parameter int REV_W     = 16,
  parameter int ERR_LIMIT = 3
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_q,
  input  logic             in_err_ack,
  output logic             o_clr,
  output logic             o_prst,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_err_sticky,
  output logic [REV_W-1:0] o_rev_cnt,
  output logic [7:0]       o_err_cnt
);

  localparam int BAD_W = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);
  localparam logic [WIDTH-1:0] RING_TOP = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] RING_BOT = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {SEEK, LOCK, FAULT, RESYNC, SETTLE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n, exp_q;
  logic [BAD_W-1:0] bad, bad_n, bad_inc;
  logic             one_hot, err_hit, rev_hit;
  logic             err_q, sticky_q;
  logic [REV_W-1:0] rev_q;
  logic [7:0]       err_cnt_q;

  assign exp_q   = {prev[0], prev[WIDTH-1:1]};
  assign one_hot = $onehot(in_q);
  assign bad_inc = bad + BAD_W'(1);

  always_comb begin
    state_n = state;
    prev_n  = prev;
    bad_n   = bad;
    err_hit = 1'b0;
    rev_hit = 1'b0;
    case (state)
      SEEK, FAULT: begin
        if (in_en) begin
          if (one_hot) begin
            prev_n  = in_q;
            bad_n   = '0;
            state_n = LOCK;
          end else begin
            bad_n = bad_inc;
            if (bad_inc >= BAD_W'(ERR_LIMIT)) state_n = RESYNC;
          end
        end
      end
      LOCK: begin
        if (in_en) begin
          if (in_q == exp_q) begin
            prev_n  = in_q;
            rev_hit = (prev == RING_BOT) && (in_q == RING_TOP);
          end else begin
            err_hit = 1'b1;
            bad_n   = BAD_W'(1);
            state_n = (ERR_LIMIT == 1) ? RESYNC : FAULT;
          end
        end
      end
      RESYNC:  state_n = SETTLE;
      SETTLE: begin
        bad_n   = '0;
        state_n = SEEK;
      end
      default: state_n = SEEK;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state     <= SEEK;
      prev      <= '0;
      bad       <= '0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      rev_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state <= state_n;
      prev  <= prev_n;
      bad   <= bad_n;
      err_q <= err_hit;
      // A new error outranks a simultaneous acknowledge.
      if (err_hit) begin
        sticky_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (in_err_ack) begin
        sticky_q <= 1'b0;
      end
      if (rev_hit) rev_q <= rev_q + REV_W'(1);
    end
  end

  assign o_clr        = (state == RESYNC);
  assign o_prst       = (state == RESYNC);
  assign o_locked     = (state == LOCK);
  assign o_err        = err_q;
  assign o_err_sticky = sticky_q;
  assign o_rev_cnt    = rev_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// tb/tb_ring_monitor.sv - scoreboard bench for ring_monitor
module tb_ring_monitor;

  localparam int ERR_LIMIT = 3;
  localparam int M_SEEK = 0, M_LOCK = 1, M_FAULT = 2, M_RESYNC = 3, M_SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, ack;
  logic [3:0]  q;
  logic        clr, prst, locked, err, sticky;
  logic [15:0] rev_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  ring_monitor #(.WIDTH(4), .REV_W(16), .ERR_LIMIT(ERR_LIMIT)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_en(en), .in_q(q), .in_err_ack(ack),
    .o_clr(clr), .o_prst(prst), .o_locked(locked), .o_err(err),
    .o_err_sticky(sticky), .o_rev_cnt(rev_cnt), .o_err_cnt(err_cnt)
  );

  typedef struct packed {
    logic        clr, prst, locked, err, sticky;
    logic [15:0] rev;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          m_st = M_SEEK;
  int          m_bad = 0;
  logic [3:0]  m_prev = '0;
  logic        m_err = 1'b0, m_sticky = 1'b0;
  logic [15:0] m_rev = '0;
  logic [7:0]  m_ecnt = '0;

  int clr_seen, err_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic [3:0] qi, input logic a);
    logic [3:0] nxt;
    logic       hit;
    nxt = {m_prev[0], m_prev[3:1]};
    hit = 1'b0;
    if (!r) begin
      m_st = M_SEEK; m_prev = '0; m_bad = 0; m_err = 1'b0;
      m_sticky = 1'b0; m_rev = '0; m_ecnt = '0;
    end else begin
      if (m_st == M_RESYNC) m_st = M_SETTLE;
      else if (m_st == M_SETTLE) begin
        m_bad = 0; m_st = M_SEEK;
      end else if (e) begin
        if (m_st == M_LOCK) begin
          if (qi == nxt) begin
            if (m_prev == 4'b0001 && qi == 4'b1000) m_rev = m_rev + 16'd1;
            m_prev = qi;
          end else begin
            hit = 1'b1; m_bad = 1; m_st = M_FAULT;
          end
        end else if ($countones(qi) == 1) begin
          m_prev = qi; m_bad = 0; m_st = M_LOCK;
        end else begin
          m_bad++;
          if (m_bad >= ERR_LIMIT) m_st = M_RESYNC;
        end
      end
      m_err = hit;
      if (hit) begin
        m_sticky = 1'b1;
        if (m_ecnt != 8'd255) m_ecnt = m_ecnt + 8'd1;
      end else if (a) m_sticky = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] qi, input logic a);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; q = qi; ack = a;
    model(r, e, qi, a);
    x.clr = (m_st == M_RESYNC); x.prst = (m_st == M_RESYNC);
    x.locked = (m_st == M_LOCK); x.err = m_err; x.sticky = m_sticky;
    x.rev = m_rev; x.ecnt = m_ecnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("clr", 32'(clr), 32'(x.clr));
    check("prst", 32'(prst), 32'(x.prst));
    check("locked", 32'(locked), 32'(x.locked));
    check("err", 32'(err), 32'(x.err));
    check("sticky", 32'(sticky), 32'(x.sticky));
    check("rev_cnt", 32'(rev_cnt), 32'(x.rev));
    check("err_cnt", 32'(err_cnt), 32'(x.ecnt));
    clr_seen += int'(clr);
    err_seen += int'(err);
  endtask

  initial begin
    logic [3:0] ring [4];
    logic [3:0] rq;
    ring[0] = 4'b1000; ring[1] = 4'b0100; ring[2] = 4'b0010; ring[3] = 4'b0001;
    rst_n = 1'b0; en = 1'b0; q = '0; ack = 1'b0;
    clr_seen = 0; err_seen = 0;

    step(0, 0, 4'b0000, 0);
    step(0, 1, 4'b1111, 1);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);

    // free-running ring from 1000
    for (int i = 0; i < 8; i++) begin
      step(1, 1, ring[i % 4], 0);
      if (i >= 1) check("t1_locked", 32'(locked), 32'd1);
    end
    check("t1_rev", 32'(rev_cnt), 32'd1);
    check("t1_no_err", 32'(err_seen), 32'd0);

    // single bad sample then correct sequence
    clr_seen = 0; err_seen = 0;
    step(1, 1, 4'b0110, 0);
    check("t2_unlocked", 32'(locked), 32'd0);
    step(1, 1, 4'b1000, 0);
    step(1, 1, 4'b0100, 0);
    step(1, 1, 4'b0010, 0);
    check("t2_err_pulses", 32'(err_seen), 32'd1);
    check("t2_err_cnt", 32'(err_cnt), 32'd1);
    check("t2_sticky", 32'(sticky), 32'd1);
    check("t2_relock", 32'(locked), 32'd1);
    check("t2_no_clr", 32'(clr_seen), 32'd0);

    // three zero samples force a resync
    clr_seen = 0;
    for (int i = 0; i < 3; i++) step(1, 1, 4'b0000, 0);
    check("t3_clr", 32'(clr), 32'd1);
    check("t3_prst", 32'(prst), 32'd1);
    step(1, 1, 4'b1000, 0);
    step(1, 1, 4'b1000, 0);
    step(1, 1, 4'b0100, 0);
    check("t3_clr_once", 32'(clr_seen), 32'd1);
    check("t3_relock", 32'(locked), 32'd1);

    // disabled with garbage input
    for (int i = 0; i < 5; i++) step(1, 0, 4'($urandom), 0);
    step(1, 1, 4'b0010, 0);
    check("t4_locked", 32'(locked), 32'd1);

    // error and ack together, then ack alone, then saturation
    step(1, 1, 4'b0011, 1);
    check("t5_sticky_err_wins", 32'(sticky), 32'd1);
    step(1, 1, 4'b0001, 0);
    step(1, 0, 4'b0000, 1);
    check("t5_sticky_acked", 32'(sticky), 32'd0);
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 4'b0110, 0);
      step(1, 1, 4'b1000, 0);
    end
    check("t5_err_sat", 32'(err_cnt), 32'd255);

    // reset while in RESYNC
    for (int i = 0; i < 3; i++) step(1, 1, 4'b0000, 0);
    check("t6_in_resync", 32'(clr), 32'd1);
    step(0, 1, 4'b0000, 0);
    check("t6_clr_off", 32'(clr), 32'd0);
    check("t6_err_cnt", 32'(err_cnt), 32'd0);
    check("t6_locked", 32'(locked), 32'd0);

    // random mix, mostly legal rotations
    for (int i = 0; i < 300; i++) begin
      rq = ($urandom_range(0, 3) != 0) ? {m_prev[0], m_prev[3:1]} : 4'($urandom);
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 4) != 0), rq,
           ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
